// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker that stalls decode until a source is forwardable.
// Define SCOREBOARD_WAW_CHECK_EN to also stall writes that would overtake an older write to the same rd.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int LATW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             issue_valid,
  input  logic             issue_regwrite,
  input  logic [4:0]       issue_rd,
  input  logic [LATW-1:0]  issue_lat,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec,
  output logic [5:0]       pending_cnt
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];
  logic             haz_a, haz_b, haz_w, set, ld, clr;
  assign haz_a = dec_use_rs1 && dec_rs1 != 5'd0 && busy_q[dec_rs1] && cnt_q[dec_rs1] != '0;
  assign haz_b = dec_use_rs2 && dec_rs2 != 5'd0 && busy_q[dec_rs2] && cnt_q[dec_rs2] != '0;
`ifdef SCOREBOARD_WAW_CHECK_EN
  assign haz_w = issue_regwrite && issue_rd != 5'd0 && busy_q[issue_rd] && cnt_q[issue_rd] > issue_lat;
`else
  assign haz_w = 1'b0;
`endif
  assign stall    = issue_valid & (haz_a | haz_b | haz_w);
  assign set      = issue_valid & ~stall & issue_regwrite & (issue_rd != 5'd0);
  assign busy_vec = busy_q;
  // A reloading issue beats a same-cycle writeback; flush beats both.
  always_comb begin
    ld  = 1'b0;
    clr = 1'b0;
    busy_d = '0;
    pending_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      ld  = set && issue_rd == 5'(i);
      clr = wb_valid && wb_rd == 5'(i) && busy_q[i];
      busy_d[i] = flush ? 1'b0 : ld ? 1'b1 : clr ? 1'b0 : busy_q[i];
      cnt_d[i]  = flush ? '0 : ld ? issue_lat : clr ? '0 : cnt_q[i] != '0 ? cnt_q[i] - 1'b1 : '0;
      pending_cnt = pending_cnt + 6'(busy_q[i]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus pushes expected stall/busy/count into a queue; a negedge monitor checks.
module tb_reg_scoreboard;
  logic        clk = 1'b0, reset = 1'b1;
  logic [4:0]  dec_rs1, dec_rs2, issue_rd, wb_rd;
  logic        dec_use_rs1, dec_use_rs2, issue_valid, issue_regwrite, wb_valid, flush;
  logic [2:0]  issue_lat;
  logic        stall;
  logic [31:0] busy_vec;
  logic [5:0]  pending_cnt;
  typedef struct {
    string       name;
    logic        st;
    logic [31:0] bv;
    logic [5:0]  pc;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  reg_scoreboard dut (
    .clk(clk), .reset(reset), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .issue_valid(issue_valid),
    .issue_regwrite(issue_regwrite), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .stall(stall),
    .busy_vec(busy_vec), .pending_cnt(pending_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (stall !== e.st || busy_vec !== e.bv || pending_cnt !== e.pc) begin
        bad++;
        $display("FAIL %s: got stall=%b busy=%h cnt=%0d, want stall=%b busy=%h cnt=%0d",
                 e.name, stall, busy_vec, pending_cnt, e.st, e.bv, e.pc);
      end
    end
  end
  task automatic exp_push(input string n, input logic s, input logic [31:0] b, input logic [5:0] p);
    exp_t e;
    e.name = n; e.st = s; e.bv = b; e.pc = p;
    q.push_back(e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic iv, input logic rw, input logic [4:0] rd, input logic [2:0] lat,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic wv, input logic [4:0] wr, input logic fl);
    issue_valid = iv; issue_regwrite = rw; issue_rd = rd; issue_lat = lat;
    dec_rs1 = r1; dec_use_rs1 = u1; dec_rs2 = r2; dec_use_rs2 = u2;
    wb_valid = wv; wb_rd = wr; flush = fl;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_push("rst", 0, 0, 0); cyc();
    drv(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0); exp_push("iss4", 0, 0, 0); cyc();
    idle(); exp_push("busy4", 0, 32'h10, 1); cyc();
    #2 reset = 1'b1; exp_push("rst_async", 0, 0, 0); cyc();
    reset = 1'b0;
    drv(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0); exp_push("raw_iss", 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); exp_push("raw_st1", 1, 32'h20, 1); cyc();
    exp_push("raw_st2", 1, 32'h20, 1); cyc();
    exp_push("raw_go", 0, 32'h20, 1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0); exp_push("raw_wb_pre", 0, 32'h20, 1); cyc();
    idle(); exp_push("raw_wb", 0, 0, 0); cyc();
    drv(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0); exp_push("x0_iss", 0, 0, 0); cyc();
    idle(); exp_push("x0", 0, 0, 0); cyc();
    drv(1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0); exp_push("u_iss", 0, 0, 0); cyc();
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); exp_push("rs2_unused", 0, 32'h20, 1); cyc();
    drv(1, 0, 0, 0, 0, 0, 5, 1, 1, 5, 0); exp_push("rs2_haz_wb", 1, 32'h20, 1); cyc();
    idle(); exp_push("wb_nobyp", 0, 0, 0); cyc();
    drv(1, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0); exp_push("iw_iss", 0, 0, 0); cyc();
    idle(); exp_push("iw_busy", 0, 32'h80, 1); cyc();
    drv(1, 1, 7, 3, 0, 0, 0, 0, 1, 7, 0); exp_push("iw_pre", 0, 32'h80, 1); cyc();
    drv(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); exp_push("iw_s3", 1, 32'h80, 1); cyc();
    exp_push("iw_s2", 1, 32'h80, 1); cyc();
    exp_push("iw_s1", 1, 32'h80, 1); cyc();
    exp_push("iw_go", 0, 32'h80, 1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0); exp_push("iw_wb", 0, 32'h80, 1); cyc();
    idle(); exp_push("iw_clr", 0, 0, 0); cyc();
    drv(1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0); exp_push("f3", 0, 0, 0); cyc();
    drv(1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0); exp_push("f4", 0, 32'h8, 1); cyc();
    drv(1, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0); exp_push("f9", 0, 32'h18, 2); cyc();
    drv(1, 1, 11, 0, 0, 0, 0, 0, 1, 4, 0); exp_push("f_iw", 0, 32'h218, 3); cyc();
    drv(1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 1); exp_push("fl_pre", 0, 32'hA08, 3); cyc();
    idle(); exp_push("flush", 0, 0, 0); cyc();
    drv(1, 1, 8, 3, 0, 0, 0, 0, 0, 0, 0); exp_push("w_iss", 0, 0, 0); cyc();
`ifdef SCOREBOARD_WAW_CHECK_EN
    drv(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0); exp_push("waw_st3", 1, 32'h100, 1); cyc();
    exp_push("waw_st2", 1, 32'h100, 1); cyc();
    exp_push("waw_go", 0, 32'h100, 1); cyc();
`else
    drv(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0); exp_push("waw_go", 0, 32'h100, 1); cyc();
`endif
    drv(1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0); exp_push("waw_c1", 1, 32'h100, 1); cyc();
    exp_push("waw_c0", 0, 32'h100, 1); cyc();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0); exp_push("waw_wb", 0, 32'h100, 1); cyc();
    idle(); exp_push("end", 0, 0, 0); cyc();
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d checks left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
